// File: rtl/fifo_sched_pkg.sv
// Shared types and width helpers for the round-robin fifo drain scheduler.
package fifo_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    // Bits needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first requesting port after i_last, wrapping modulo N_PORTS.
module rr_pick
    import fifo_sched_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int SRC_W   = clog2_min1(N_PORTS)
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [SRC_W-1:0]   i_last,
    output logic [SRC_W-1:0]   o_gnt_idx,
    output logic               o_gnt_any
);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest requester after i_last wins.
    always_comb begin
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        w_idx     = 0;
        for (int off = N_PORTS; off >= 1; off--) begin
            w_idx = int'(i_last) + off;
            if (w_idx >= N_PORTS) begin
                w_idx = w_idx - N_PORTS;
            end else begin
                w_idx = w_idx;
            end
            if (w_idx >= N_PORTS) begin
                w_idx = w_idx - N_PORTS;
            end else begin
                w_idx = w_idx;
            end
            if (i_req[w_idx[SRC_W-1:0]]) begin
                o_gnt_idx = w_idx[SRC_W-1:0];
                o_gnt_any = 1'b1;
            end else begin
                o_gnt_any = o_gnt_any;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_drain_sched.sv
// Drains N_PORTS fifos into one valid/ready stream, round-robin with bursts of up to BURST_LEN.
module fifo_rr_drain_sched
    import fifo_sched_pkg::*;
#(
    parameter  int N_PORTS    = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int BURST_LEN  = 4,
    localparam int SRC_W      = clog2_min1(N_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_en,
    input  logic [N_PORTS-1:0]            i_fifo_empty,
    output logic [N_PORTS-1:0]            o_fifo_rd_en,
    input  logic [N_PORTS*DATA_WIDTH-1:0] i_fifo_dout,
    output logic [DATA_WIDTH-1:0]         o_out_data,
    output logic [SRC_W-1:0]              o_out_src,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic                          o_busy
);

    localparam int CNT_W = clog2_min1(BURST_LEN + 1);

    state_e                r_state;
    logic [SRC_W-1:0]      r_last_grant;
    logic [SRC_W-1:0]      r_cur;
    logic [CNT_W-1:0]      r_burst_cnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [SRC_W-1:0]      r_out_src;

    logic                  w_can_load;
    logic                  w_cur_empty;
    logic                  w_rd;
    logic                  w_burst_last;
    logic [DATA_WIDTH-1:0] w_dout;
    logic [SRC_W-1:0]      w_gnt_idx;
    logic                  w_gnt_any;

    rr_pick #(
        .N_PORTS (N_PORTS),
        .SRC_W   (SRC_W)
    ) u_rr_pick (
        .i_req     (~i_fifo_empty),
        .i_last    (r_last_grant),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_gnt_any)
    );

    assign w_can_load   = !r_out_valid || i_out_ready;
    assign w_burst_last = (r_burst_cnt == CNT_W'(BURST_LEN - 1));
    assign w_rd         = !reset && (r_state == SERVE) && i_en && !w_cur_empty && w_can_load;

    // Select the current port's empty flag and data; an out-of-range index reads as empty.
    always_comb begin
        w_cur_empty = 1'b1;
        w_dout      = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (r_cur == SRC_W'(k)) begin
                w_cur_empty = i_fifo_empty[k];
                w_dout      = i_fifo_dout[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w_cur_empty = w_cur_empty;
            end
        end
    end

    // One-hot read strobe towards the granted fifo.
    always_comb begin
        o_fifo_rd_en = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            o_fifo_rd_en[k] = w_rd && (r_cur == SRC_W'(k));
        end
    end

    // Arbitration FSM: one IDLE cycle to pick, then SERVE until empty, disabled or burst done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= SRC_W'(N_PORTS - 1);
            r_cur        <= '0;
            r_burst_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_en && w_gnt_any) begin
                        r_cur       <= w_gnt_idx;
                        r_burst_cnt <= '0;
                        r_state     <= SERVE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SERVE: begin
                    if (!i_en || w_cur_empty) begin
                        r_last_grant <= r_cur;
                        r_state      <= IDLE;
                    end else if (w_can_load) begin
                        if (w_burst_last) begin
                            r_burst_cnt  <= '0;
                            r_last_grant <= r_cur;
                            r_state      <= IDLE;
                        end else begin
                            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_state <= SERVE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Output register: load on a read, otherwise drop valid once the word is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_rd) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_dout;
            r_out_src   <= r_cur;
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_src   = r_out_src;
    assign o_busy      = (r_state == SERVE);

endmodule

// File: tb/tb_fifo_rr_drain_sched.sv
// Directed bench with behavioural fifos and a scoreboard monitor on the output stream.
module tb_fifo_rr_drain_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  fifo_empty = 4'hF;
    logic [3:0]  rd_en;
    logic [63:0] fifo_dout = 64'h0;
    logic [15:0] out_data;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    logic [15:0] fq [4][$];
    logic [17:0] exp_q [$];
    int          rd_count [4];
    int          total = 0;
    int          bad   = 0;

    fifo_rr_drain_sched #(
        .N_PORTS    (4),
        .DATA_WIDTH (16),
        .BURST_LEN  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_en         (en),
        .i_fifo_empty (fifo_empty),
        .o_fifo_rd_en (rd_en),
        .i_fifo_dout  (fifo_dout),
        .o_out_data   (out_data),
        .o_out_src    (out_src),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < 4; k++) rd_count[k] = 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural fifos: registered empty flag and data head, popped on rd_en.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rd_en[k] && fq[k].size() != 0) begin
                fq[k].delete(0);
                rd_count[k] <= rd_count[k] + 1;
            end
            fifo_empty[k] <= (fq[k].size() == 0);
            fifo_dout[k*16 +: 16] <= (fq[k].size() != 0) ? fq[k][0] : 16'h0;
        end
    end

    // Monitor: scoreboard on accepted words, plus underflow and one-hot read checks.
    always @(negedge clk) begin
        if (rd_en != 4'h0) begin
            chk("rd_onehot", {31'd0, $countones(rd_en) == 1}, 32'd1);
            for (int k = 0; k < 4; k++) begin
                if (rd_en[k]) chk("no_underflow", {31'd0, fq[k].size() != 0}, 32'd1);
            end
        end
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {14'd0, out_src, out_data}, 32'h0);
            end else begin
                chk("word", {14'd0, out_src, out_data}, {14'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [15:0] d);
        fq[k].push_back(d);
        exp_q.push_back({2'(k), d});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            step();
            n++;
        end
        chk(name, exp_q.size(), 32'd0);
    endtask

    logic [3:0] t2_rd    [6] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    logic       t2_busy  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       t2_valid [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int nv, bub, n, r1, r2;
        reset     = 1'b1;
        en        = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) fq[k].push_back(16'hEE00 + 16'(k));
        step();
        step();

        // 1: reset held with every fifo non-empty
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_rd_en", {28'd0, rd_en}, 32'd0);
            chk("rst_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        step();
        for (int k = 0; k < 4; k++) fq[k].delete();
        step();
        step();

        // 2: single port with three words
        load(2, 16'hA001);
        load(2, 16'hB002);
        load(2, 16'hC003);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_rd_en", {28'd0, rd_en}, {28'd0, t2_rd[i]});
            chk("t2_busy", {31'd0, busy}, {31'd0, t2_busy[i]});
            chk("t2_valid", {31'd0, out_valid}, {31'd0, t2_valid[i]});
        end
        drain("t2_drain");

        // 3: four full ports, bursts of four in rotation
        step();
        reset = 1'b1;
        step();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 10; i++) fq[k].push_back({4'(k), 12'h100 + 12'(i)});
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < 4; j++) exp_q.push_back({2'(k), 4'(k), 12'h100 + 12'(r*4 + j)});
        for (int k = 0; k < 4; k++)
            for (int j = 8; j < 10; j++) exp_q.push_back({2'(k), 4'(k), 12'h100 + 12'(j)});
        step();
        step();
        reset = 1'b0;
        nv  = 0;
        bub = 0;
        n   = 0;
        while (nv < 32 && n < 200) begin
            @(negedge clk);
            if (out_valid) nv++;
            else if (nv > 0) bub++;
            n++;
        end
        chk("t3_words32", nv, 32'd32);
        chk("t3_bubbles", bub, 32'd7);
        drain("t3_drain");

        // 4: backpressure while a word is held
        for (int i = 0; i < 4; i++) load(0, {4'h0, 12'h400 + 12'(i)});
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("t4_first_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_bp_rd_en", {28'd0, rd_en}, 32'd0);
            chk("t4_bp_data", {16'd0, out_data}, 32'h0400);
            chk("t4_bp_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        drain("t4_drain");

        // 5: port 1 empties before its burst ends; port 2 follows
        r1 = rd_count[1];
        r2 = rd_count[2];
        load(1, 16'h1500);
        load(1, 16'h1501);
        for (int i = 0; i < 3; i++) load(2, {4'h2, 12'h510 + 12'(i)});
        drain("t5_drain");
        chk("t5_p1_reads", rd_count[1] - r1, 32'd2);
        chk("t5_p2_reads", rd_count[2] - r2, 32'd3);

        // 6: reset while the second word is held and the third would be read
        fq[3].push_back(16'h3600);
        fq[3].push_back(16'h3601);
        fq[3].push_back(16'h3602);
        fq[3].push_back(16'h3603);
        fq[0].push_back(16'h06F0);
        exp_q.push_back({2'd3, 16'h3600});
        exp_q.push_back({2'd0, 16'h06F0});
        exp_q.push_back({2'd3, 16'h3602});
        exp_q.push_back({2'd3, 16'h3603});
        n = 0;
        while (!(out_valid && out_data == 16'h3601) && n < 30) begin
            step();
            n++;
        end
        chk("t6_second_word", {16'd0, out_data}, 32'h3601);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_rd_en", {28'd0, rd_en}, 32'd0);
        step();
        @(negedge clk);
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        drain("t6_drain");
        chk("t6_p3_left", fq[3].size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
